weight_fetch_ctrl: RTL and testbench
====================================

// Module: weight_fetch_ctrl
// PURPOSE
//   Sequences the synchronous weight ROM for one layer. On start it sweeps num_inputs*num_neurons
//   consecutive ROM addresses from base_addr and streams weights to the MAC array over a
//   valid/ready interface, tagging neuron and layer boundaries. A 2-entry skid FIFO absorbs the
//   1-cycle ROM read latency so that downstream back-pressure never drops or duplicates a weight.
// PARAMETERS
//   N       8  weight word width (signed, Q-format fixed point)
//   Q       7  fractional bits; pass-through only, no arithmetic on weights
//   ADDR_W  8  ROM address width; ROM depth is 2**ADDR_W
// PORTS
//   clk          in   1       system clock; all state updates on posedge
//   rst_n        in   1       asynchronous, active-low reset
//   start        in   1       1-cycle pulse; samples base_addr/num_inputs/num_neurons
//   base_addr    in   ADDR_W  first ROM address of the layer
//   num_inputs   in   8       weights per neuron (fan-in)
//   num_neurons  in   8       neurons in the layer
//   busy         out  1       high from accepted start until done
//   done         out  1       1-cycle pulse once the final weight has been accepted
//   rom_addr     out  ADDR_W  registered ROM address
//   rom_data     in   N       ROM output; valid the cycle after rom_addr is updated
//   w_data       out  N       weight to MAC, signed
//   w_valid      out  1       w_data valid
//   w_ready      in   1       MAC accepts; beat transfers when w_valid & w_ready
//   w_last_in    out  1       beat is the final input of the current neuron
//   w_last       out  1       beat is the final weight of the layer (implies w_last_in)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; busy=0, done=0, w_valid=0, w_last_in=0, w_last=0,
//     rom_addr=0, w_data=0; FIFO flushed; in-flight read discarded. Reset mid-layer aborts silently.
//   FSM: IDLE -(start)-> FETCH -(last address issued)-> DRAIN -(last beat accepted)-> IDLE.
//     A done pulse accompanies the DRAIN->IDLE transition.
//   start is ignored while busy=1. start with num_inputs==0 or num_neurons==0: no ROM reads,
//     no beats; done pulses on the next cycle and busy stays 0.
//   Issue rule: in FETCH, a read issues (rom_addr <= next addr, inflight=1) in cycle t only if
//     fifo_count + inflight - pop(t) < 2, where pop = w_valid & w_ready. The read returns in
//     t+1 and is pushed into the FIFO at the end of t+1.
//   Addressing: beat k (0..num_inputs*num_neurons-1) reads addr = (base_addr + k) mod 2**ADDR_W.
//     Wrap past the top of the ROM is legal and silent. The beat counter is 16 bits.
//   Tags: input index i and neuron index j are carried with each read. w_last_in is set when
//     i==num_inputs-1; w_last is set when j==num_neurons-1 as well.
//   Output: w_data/w_valid/w_last* are driven from the FIFO head. Data is held stable while
//     w_valid & !w_ready. Throughput is 1 beat/cycle with w_ready held high.
//   Latency: first w_valid occurs 2 cycles after start (issue cycle + ROM cycle).
//   Push and pop in the same cycle are legal at any occupancy; the FIFO never exceeds 2 entries.
//   The weight passes through untouched; sign and width are preserved.
// TESTING
//   1. base=0x10, inputs=3, neurons=2, w_ready=1 -> 6 beats, addrs 0x10..0x15 in order on
//      consecutive cycles; w_last_in on beats 2 and 5; w_last on beat 5; done 1 cycle later.
//   2. Same as 1 with w_ready toggled 1,0,0,1 repeating -> identical 6-weight sequence with no
//      drops or duplicates; w_data held stable while stalled.
//   3. base=0xFE, inputs=4, neurons=1 -> addrs 0xFE,0xFF,0x00,0x01; ROM 0x80 read at 0x00
//      appears as signed -128.
//   4. num_inputs=0 -> no w_valid; done pulses next cycle; busy never asserts. A second start
//      sent while busy during test 1 -> ignored, beat count unchanged.
//   5. rst_n low after the 3rd beat of test 1 -> all outputs are 0 immediately. A new start
//      then replays from base_addr correctly.
//   6. inputs=255, neurons=255, random w_ready -> exactly 65025 beats, 255 w_last_in pulses,
//      1 w_last pulse, addresses mod 256.

Source files
------------

// File: rtl/weight_fetch_ctrl.sv
// Purpose: sweeps the weight ROM for one layer and streams weights to the MAC array with neuron/layer tags.
// Latency: first w_valid_o two cycles after start_i (ROM address issue cycle + ROM read cycle), then 1 beat/cycle.
// Backpressure: a 2-entry skid FIFO absorbs the in-flight ROM read; reads stop issuing when FIFO + in-flight would exceed 2.
module weight_fetch_ctrl #(
    parameter int N      = 8,
    parameter int Q      = 7,
    parameter int ADDR_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   base_addr_i,
    input  logic [7:0]          num_inputs_i,
    input  logic [7:0]          num_neurons_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [ADDR_W-1:0]   rom_addr_o,
    input  logic [N-1:0]        rom_data_i,
    output logic signed [N-1:0] w_data_o,
    output logic                w_valid_o,
    input  logic                w_ready_i,
    output logic                w_last_in_o,
    output logic                w_last_o
);

    // Q is only the fixed-point interpretation of the weight; it must fit inside the word.
    if (Q >= N) begin : g_bad_q
        $error("weight_fetch_ctrl: Q must be smaller than N");
    end

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [7:0]        ni_q, nn_q;
    logic [7:0]        i_q, i_d, j_q, j_d;
    logic [15:0]       k_q, k_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              infl_q, infl_last_in_q, infl_last_q;
    logic [1:0]        cnt_q, cnt_d;
    logic [N+1:0]      e0_q, e0_d, e1_q, e1_d;
    logic              done_q, done_d;

    logic              start_ok, start_nz;
    logic [ADDR_W-1:0] iss_base;
    logic [7:0]        iss_ni, iss_nn, iss_i, iss_j;
    logic [15:0]       iss_k;
    logic              iss_last_in, iss_last;
    logic              pop, push, room, issue;
    logic [2:0]        occ;
    logic [N+1:0]      push_ent;

    assign start_ok = start_i && (state_q == S_IDLE);
    assign start_nz = start_ok && (num_inputs_i != 8'd0) && (num_neurons_i != 8'd0);

    // The first read issues in the start cycle straight from the ports; later reads use the latched layer.
    always_comb begin
        iss_base = base_q;
        iss_ni   = ni_q;
        iss_nn   = nn_q;
        iss_i    = i_q;
        iss_j    = j_q;
        iss_k    = k_q;
        if (state_q == S_IDLE) begin
            iss_base = base_addr_i;
            iss_ni   = num_inputs_i;
            iss_nn   = num_neurons_i;
            iss_i    = 8'd0;
            iss_j    = 8'd0;
            iss_k    = 16'd0;
        end
    end

    assign iss_last_in = (iss_i == iss_ni - 8'd1);
    assign iss_last    = iss_last_in && (iss_j == iss_nn - 8'd1);

    assign pop      = w_valid_o && w_ready_i;
    assign push     = infl_q;
    assign push_ent = {infl_last_q, infl_last_in_q, rom_data_i};
    assign occ      = {1'b0, cnt_q} + {2'b00, infl_q};
    // Space must remain for the read issued now once it lands, counting the beat leaving this cycle.
    assign room     = pop ? (occ <= 3'd2) : (occ <= 3'd1);
    assign issue    = start_nz || ((state_q == S_FETCH) && room);

    // Sequencer: address/tag counters, FSM transitions and the done pulse.
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        done_d     = 1'b0;
        if (issue) begin
            rom_addr_d = iss_base + iss_k[ADDR_W-1:0];
            k_d        = iss_k + 16'd1;
            i_d        = iss_last_in ? 8'd0 : iss_i + 8'd1;
            j_d        = iss_last_in ? iss_j + 8'd1 : iss_j;
            state_d    = iss_last ? S_DRAIN : S_FETCH;
        end
        if (start_ok && !start_nz) begin
            done_d = 1'b1;
        end
        if ((state_q == S_DRAIN) && pop && w_last_o) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end
    end

    // Skid FIFO: e0 is the head presented downstream, e1 only fills while the head is stalled.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = push_ent;
                else               e1_d = push_ent;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    e0_d = e1_q;
                    e1_d = push_ent;
                end else begin
                    e0_d = push_ent;
                end
            end
            default: ;
        endcase
    end

    // State registers; reset discards the in-flight read and flushes the FIFO.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= S_IDLE;
            base_q         <= '0;
            ni_q           <= '0;
            nn_q           <= '0;
            i_q            <= '0;
            j_q            <= '0;
            k_q            <= '0;
            rom_addr_q     <= '0;
            infl_q         <= 1'b0;
            infl_last_in_q <= 1'b0;
            infl_last_q    <= 1'b0;
            cnt_q          <= '0;
            e0_q           <= '0;
            e1_q           <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            if (start_ok) begin
                base_q <= base_addr_i;
                ni_q   <= num_inputs_i;
                nn_q   <= num_neurons_i;
            end
            i_q            <= i_d;
            j_q            <= j_d;
            k_q            <= k_d;
            rom_addr_q     <= rom_addr_d;
            infl_q         <= issue;
            infl_last_in_q <= issue && iss_last_in;
            infl_last_q    <= issue && iss_last;
            cnt_q          <= cnt_d;
            e0_q           <= e0_d;
            e1_q           <= e1_d;
            done_q         <= done_d;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign rom_addr_o  = rom_addr_q;
    assign w_valid_o   = (cnt_q != 2'd0);
    assign w_data_o    = e0_q[N-1:0];
    assign w_last_in_o = w_valid_o && e0_q[N];
    assign w_last_o    = w_valid_o && e0_q[N+1];

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
module tb_weight_fetch_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, busy, done, w_valid, w_ready, w_last_in, w_last;
    logic [7:0] base, ni, nn, rom_addr, rom_data;
    logic signed [7:0] w_data;

    weight_fetch_ctrl #(.N(8), .Q(7), .ADDR_W(8)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .start_i       (start),
        .base_addr_i   (base),
        .num_inputs_i  (ni),
        .num_neurons_i (nn),
        .busy_o        (busy),
        .done_o        (done),
        .rom_addr_o    (rom_addr),
        .rom_data_i    (rom_data),
        .w_data_o      (w_data),
        .w_valid_o     (w_valid),
        .w_ready_i     (w_ready),
        .w_last_in_o   (w_last_in),
        .w_last_o      (w_last)
    );

    // Synchronous ROM: the address is a register inside the DUT, so data is valid the following cycle.
    logic [7:0] rom [256];
    assign rom_data = rom[rom_addr];

    typedef struct packed {
        logic [7:0] d;
        logic       li;
        logic       l;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0, errors = 0;
    int    done_cnt = 0, done_base = 0, beats_seen = 0, li_cnt = 0, l_cnt = 0;
    bit    saw_m128 = 0;
    int    rdy_mode = 0, phase = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ready driver: 0 = always, 1 = pattern 1,0,0,1, 2 = mostly ready, 3 = coin flip.
    initial begin
        w_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: w_ready = 1'b1;
                1: begin
                    w_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
                    phase++;
                end
                2: w_ready = ($urandom_range(0, 15) != 0);
                default: w_ready = ($urandom_range(0, 1) != 0);
            endcase
        end
    end

    // Monitor: pops expected beats on each handshake, checks stall stability and done timing.
    logic  prev_stall = 1'b0;
    beat_t prev_b, b, e;
    bit    exp_done = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_done   = 0;
            prev_stall = 1'b0;
        end else begin
            b = {w_data, w_last_in, w_last};
            if (done || exp_done) check("done_pulse", 64'(done), 64'(exp_done));
            if (done) done_cnt++;
            exp_done = 0;
            if (start && !busy && (ni == 8'd0 || nn == 8'd0)) exp_done = 1;
            if (prev_stall) begin
                check("hold_valid", 64'(w_valid), 64'd1);
                check("hold_beat", 64'(b), 64'(prev_b));
            end
            if (w_valid && w_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got %0h expected none", b);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'(b), 64'(e));
                    if (e.l) exp_done = 1;
                end
                beats_seen++;
                if (w_last_in) li_cnt++;
                if (w_last) l_cnt++;
                if (w_data == -8'sd128) saw_m128 = 1;
            end
            prev_stall = w_valid && !w_ready;
            prev_b     = b;
        end
    end

    task automatic start_layer(input logic [7:0] b_i, input logic [7:0] n_in, input logic [7:0] n_ne, input bit accept);
        logic [7:0] a;
        @(posedge clk);
        #1;
        start = 1'b1;
        base = b_i;
        ni = n_in;
        nn = n_ne;
        phase = 0;
        done_base = done_cnt;
        if (accept) begin
            for (int j = 0; j < int'(n_ne); j++) begin
                for (int i = 0; i < int'(n_in); i++) begin
                    a = 8'(int'(b_i) + j * int'(n_in) + i);
                    exp_q.push_back({rom[a], i == int'(n_in) - 1, (i == int'(n_in) - 1) && (j == int'(n_ne) - 1)});
                end
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done_cnt == done_base && n < budget) begin
            @(posedge clk);
            n++;
        end
        check({name, "_done_seen"}, 64'(done_cnt != done_base), 64'd1);
        @(negedge clk);
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        check({name, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    task automatic clear_counts();
        beats_seen = 0;
        li_cnt = 0;
        l_cnt = 0;
    endtask

    initial begin
        logic [7:0] mult;
        int n;
        rst_n = 1'b1;
        start = 1'b0;
        base = 8'd0;
        ni = 8'd0;
        nn = 8'd0;
        // Affine odd-multiplier map is a bijection, so every address has a distinct weight; rom[0] = 0x80.
        mult = 8'($urandom_range(0, 127) * 2 + 1);
        for (int a = 0; a < 256; a++) rom[a] = 8'(a * int'(mult) + 128);
        #1 rst_n = 1'b0;
        #11;
        check("reset_outputs", 64'({busy, done, w_valid, w_last_in, w_last, rom_addr, w_data}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: back-to-back stream, latency, ignored start while busy.
        rdy_mode = 0;
        clear_counts();
        start_layer(8'h10, 8'd3, 8'd2, 1'b1);
        @(negedge clk);
        check("t1_no_valid_cycle1", 64'(w_valid), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            start = (c == 1);
            if (c == 1) begin
                base = 8'h40;
                ni = 8'd5;
                nn = 8'd1;
            end
            @(negedge clk);
            check("t1_stream_valid", 64'(w_valid), 64'd1);
        end
        wait_done(50, "t1");
        check("t1_beats", 64'(beats_seen), 64'd6);
        check("t1_last_in", 64'(li_cnt), 64'd2);
        check("t1_last", 64'(l_cnt), 64'd1);

        // Test 2: ready pattern 1,0,0,1.
        rdy_mode = 1;
        clear_counts();
        start_layer(8'h10, 8'd3, 8'd2, 1'b1);
        wait_done(200, "t2");
        check("t2_beats", 64'(beats_seen), 64'd6);

        // Test 3: address wrap and sign preservation.
        rdy_mode = 3;
        clear_counts();
        saw_m128 = 0;
        start_layer(8'hFE, 8'd4, 8'd1, 1'b1);
        wait_done(200, "t3");
        check("t3_beats", 64'(beats_seen), 64'd4);
        check("t3_neg128", 64'(saw_m128), 64'd1);

        // Test 4: empty layers.
        rdy_mode = 0;
        clear_counts();
        start_layer(8'h20, 8'd0, 8'd3, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t4_busy_low", 64'(busy), 64'd0);
            check("t4_no_valid", 64'(w_valid), 64'd0);
        end
        wait_done(10, "t4a");
        start_layer(8'h20, 8'd5, 8'd0, 1'b0);
        wait_done(10, "t4b");
        check("t4_beats", 64'(beats_seen), 64'd0);

        // Test 5: reset mid-layer, then replay.
        rdy_mode = 0;
        clear_counts();
        start_layer(8'h10, 8'd3, 8'd2, 1'b1);
        n = 0;
        while (beats_seen < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_three_beats", 64'(beats_seen), 64'd3);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_reset_outputs", 64'({busy, done, w_valid, w_last_in, w_last, rom_addr, w_data}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        start_layer(8'h10, 8'd3, 8'd2, 1'b1);
        wait_done(50, "t5");
        check("t5_beats", 64'(beats_seen), 64'd6);
        check("t5_last", 64'(l_cnt), 64'd1);

        // Test 6: full-size layer with random back-pressure.
        rdy_mode = 2;
        clear_counts();
        start_layer(8'h37, 8'd255, 8'd255, 1'b1);
        wait_done(90000, "t6");
        check("t6_beats", 64'(beats_seen), 64'd65025);
        check("t6_last_in", 64'(li_cnt), 64'd255);
        check("t6_last", 64'(l_cnt), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
